seg7_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one Seg7decode instance and one segment bus across four common-anode digits. It snapshots four 4-bit values once per frame, then steps a digit index. The index selects which nibble drives the decoder and which anode is enabled. Each digit slot begins with a dead-time interval to suppress ghosting. It sits between the counter/data logic and the board display pins, replacing the single-digit direct hookup.

---
 rtl/seg7_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan scheduler: frame snapshot, per-slot dead time, one shared decoder nibble.
// Outputs decode straight from registers with no input-to-output path; free-running while enabled, no backpressure.
module seg7_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_mask,
    input  logic        lz_blank,
    output logic [3:0]  bin,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic          frame_tick_q, frame_tick_d;
    logic [15:0]   snap_digits_q, snap_digits_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic [3:0]    snap_mask_q, snap_mask_d;
    logic          snap_lz_q, snap_lz_d;
    logic          load_snap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            slot_cnt_q    <= '0;
            frame_tick_q  <= 1'b0;
            snap_digits_q <= 16'h0000;
            snap_dp_q     <= 4'h0;
            snap_mask_q   <= 4'h0;
            snap_lz_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            slot_cnt_q    <= slot_cnt_d;
            frame_tick_q  <= frame_tick_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_mask_q   <= snap_mask_d;
            snap_lz_q     <= snap_lz_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        slot_cnt_d   = slot_cnt_q;
        frame_tick_d = 1'b0;
        load_snap    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d      = BLANK;
                    idx_d        = 2'd0;
                    slot_cnt_d   = '0;
                    frame_tick_d = 1'b1;
                    load_snap    = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d    = IDLE;
                    idx_d      = 2'd0;
                    slot_cnt_d = '0;
                end else begin
                    slot_cnt_d = slot_cnt_q + CW'(1);
                    if (slot_cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                // Disable takes priority over the slot-end advance.
                if (!enable) begin
                    state_d    = IDLE;
                    idx_d      = 2'd0;
                    slot_cnt_d = '0;
                end else if (slot_cnt_q == SLOT_LAST) begin
                    state_d    = BLANK;
                    slot_cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        idx_d        = 2'd0;
                        frame_tick_d = 1'b1;
                        load_snap    = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                idx_d      = 2'd0;
                slot_cnt_d = '0;
            end
        endcase

        snap_digits_d = load_snap ? digits     : snap_digits_q;
        snap_dp_d     = load_snap ? dp_in      : snap_dp_q;
        snap_mask_d   = load_snap ? digit_mask : snap_mask_q;
        snap_lz_d     = load_snap ? lz_blank   : snap_lz_q;
    end

    logic [3:0] cur_nibble;
    logic       upper_zero;
    logic       visible;
    logic       lit;

    always_comb begin
        cur_nibble = 4'h0;
        upper_zero = 1'b0;
        // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
        case (idx_q)
            2'd0: begin
                cur_nibble = snap_digits_q[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                cur_nibble = snap_digits_q[7:4];
                upper_zero = (snap_digits_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nibble = snap_digits_q[11:8];
                upper_zero = (snap_digits_q[15:8] == 8'h00);
            end
            default: begin
                cur_nibble = snap_digits_q[15:12];
                upper_zero = (snap_digits_q[15:12] == 4'h0);
            end
        endcase

        visible = snap_mask_q[idx_q] & ~(snap_lz_q & upper_zero);
        lit     = (state_q == SHOW) & visible;

        an = 4'b1111;
        if (lit) begin
            an[idx_q] = 1'b0;
        end
        dp        = ~(lit & snap_dp_q[idx_q]);
        bin       = (state_q == IDLE) ? 4'h0 : cur_nibble;
        digit_sel = idx_q;
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2: frame-position reference model, directed and random stimulus.
module tb_seg7_scan_ctrl;

    localparam int CLK_DIV = 8;
    localparam int BLANKC  = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_mask;
    logic        lz_blank;
    logic [3:0]  bin;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    seg7_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANKC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .digits(digits), .dp_in(dp_in),
        .digit_mask(digit_mask), .lz_blank(lz_blank), .bin(bin), .an(an), .dp(dp),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame plus the frame's snapshot.
    bit          m_run;
    int          m_t;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [3:0]  m_mask;
    logic        m_lz;

    logic [3:0]  e_an, e_bin;
    logic        e_dp, e_tick, e_run;
    logic [1:0]  e_sel;

    function automatic void model_reset();
        m_run = 0; m_t = 0; m_dig = 16'h0; m_dp = 4'h0; m_mask = 4'h0; m_lz = 1'b0;
    endfunction

    function automatic void model_snap();
        m_dig = digits; m_dp = dp_in; m_mask = digit_mask; m_lz = lz_blank;
    endfunction

    function automatic void model_step();
        if (!rst) begin
            model_reset();
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1; m_t = 0; model_snap();
            end
        end else if (!enable) begin
            m_run = 0; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) model_snap();
        end
    endfunction

    function automatic void model_expect();
        int  d;
        bit  show, vis;
        d    = m_run ? (m_t / CLK_DIV) : 0;
        show = m_run && ((m_t % CLK_DIV) >= BLANKC);
        vis  = m_mask[d] && !(m_lz && d >= 1 && ((m_dig >> (4 * d)) == 16'h0));
        e_run  = m_run;
        e_sel  = 2'(d);
        e_bin  = m_dig[4*d +: 4];
        e_an   = (show && vis) ? ~(4'b0001 << d) : 4'b1111;
        e_dp   = !(show && vis && m_dp[d]);
        e_tick = m_run && (m_t == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        model_expect();
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; digits = 16'h4321; dp_in = 4'h0; digit_mask = 4'hF; lz_blank = 1'b0;
        model_reset();
        #3;
        checks++;
        if (an !== 4'b1111 || dp !== 1'b1 || bin !== 4'h0 || digit_sel !== 2'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial an=%b dp=%b bin=%h sel=%0d tick=%b (want 1111 1 0 0 0)", an, dp, bin, digit_sel, frame_tick);
        end
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL reset_start t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
        end
        // Now in digit-1 SHOW; assert reset between edges.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (an !== 4'b1111 || dp !== 1'b1 || bin !== 4'h0 || digit_sel !== 2'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_async an=%b dp=%b bin=%h sel=%0d tick=%b (want 1111 1 0 0 0)", an, dp, bin, digit_sel, frame_tick);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL reset_release t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
        end
    endtask

    task automatic test_basic_scan();
        int ticks = 0;
        digits = 16'h4321; dp_in = 4'h0; digit_mask = 4'hF; lz_blank = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (frame_tick === 1'b1) ticks++;
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL basic_scan t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("FAIL basic_tick_count got %0d want 3", ticks);
        end
    endtask

    task automatic test_leading_zeros();
        digit_mask = 4'hF; dp_in = 4'hF; lz_blank = 1'b1;
        for (int p = 0; p < 2; p++) begin
            digits = (p == 0) ? 16'h0050 : 16'h0000;
            for (int i = 0; i < 2 * FRAME; i++) begin
                step();
                checks++;
                if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                    errors++;
                    $display("FAIL leading_zeros t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        bit changed = 0;
        digits = 16'h1234; dp_in = 4'h0; digit_mask = 4'hF; lz_blank = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL snapshot t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
            if (!changed && i >= FRAME && m_dig == 16'h1234 && m_t / CLK_DIV == 1) begin
                digits = 16'hABCD;
                changed = 1;
            end
        end
        checks++;
        if (!changed || m_dig !== 16'hABCD) begin
            errors++;
            $display("FAIL snapshot_setup changed=%0d snap=%h want ABCD", changed, m_dig);
        end
    endtask

    task automatic test_mask_dp();
        digits = 16'h9876; digit_mask = 4'b0101; dp_in = 4'b0001; lz_blank = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step();
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL mask_dp t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
        end
    endtask

    task automatic test_enable_drop();
        int guard = 0;
        digits = 16'h5678; digit_mask = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
        while (!(m_run && m_t / CLK_DIV == 2 && m_t % CLK_DIV == 4) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 2 * FRAME) begin
            errors++;
            $display("FAIL enable_drop_wait slot2 SHOW not reached in %0d cycles", guard);
        end
        enable = 1'b0;
        step();
        checks++;
        if (an !== 4'b1111 || digit_sel !== 2'd0 || frame_tick !== 1'b0 || an !== e_an) begin
            errors++;
            $display("FAIL enable_drop an=%b sel=%0d tick=%b (want 1111 0 0)", an, digit_sel, frame_tick);
        end
        enable = 1'b1;
        for (int i = 0; i < CLK_DIV + 2; i++) begin
            step();
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL enable_restart t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            step();
            checks++;
            if (an !== e_an || dp !== e_dp || digit_sel !== e_sel || frame_tick !== e_tick || (e_run && bin !== e_bin)) begin
                errors++;
                $display("FAIL random t=%0t an=%b/%b dp=%b/%b bin=%h/%h sel=%0d/%0d tick=%b/%b", $time, an, e_an, dp, e_dp, bin, e_bin, digit_sel, e_sel, frame_tick, e_tick);
            end
            if ($urandom_range(0, 9) == 0) begin
                for (int n = 0; n < 4; n++)
                    digits[4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                dp_in      = 4'($urandom_range(0, 15));
                digit_mask = 4'($urandom_range(0, 15));
                lz_blank   = 1'($urandom_range(0, 1));
            end
            if (!enable) enable = 1'b1;
            else if ($urandom_range(0, 59) == 0) enable = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_leading_zeros();
        test_snapshot();
        test_mask_dp();
        test_enable_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
